// File: rtl/button_io_mem.sv
// button_io_mem: memory-mapped debounced buttons with sticky W1C press/release events and a masked irq,
// plus PWM-driven RGB LEDs whose colours latch into shadow registers at each PWM period start.
module button_io_mem #(
   parameter int DATA_WIDTH      = 16,
   parameter int ADDR_WIDTH      = 16,
   parameter int NUM_BUTTONS     = 8,
   parameter int NUM_LEDS        = 2,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int PWM_BITS        = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DATA_WIDTH-1:0]   data,
   input  logic [ADDR_WIDTH-1:0]   addr,
   input  logic                    we,
   input  logic                    en,
   output logic [DATA_WIDTH-1:0]   q,
   input  logic [NUM_BUTTONS-1:0]  buttons,
   output logic                    irq,
   output logic [3*NUM_LEDS-1:0]   led_pins
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [NUM_BUTTONS-1:0] sync1_q, sync2_q, stable_q, stable_d;
   logic [NUM_BUTTONS-1:0] press_q, press_d, release_q, release_d, irq_en_q, irq_en_d;
   logic [CW-1:0]          cnt_q [NUM_BUTTONS];
   logic [CW-1:0]          cnt_d [NUM_BUTTONS];
   logic [14:0]            color_q [NUM_LEDS];
   logic [14:0]            color_d [NUM_LEDS];
   logic [14:0]            shadow_q [NUM_LEDS];
   logic [PWM_BITS-1:0]    pwm_q;
   logic [3*NUM_LEDS-1:0]  led_q, led_d;
   logic                   irq_q, irq_d;
   logic                   wr_en;
   logic [3:0]             addr_lo;
   logic                   unused_bits;

   assign wr_en       = en && we;
   assign addr_lo     = addr[3:0];
   assign unused_bits = ^{addr[ADDR_WIDTH-1:4], data[DATA_WIDTH-1]};

   always_comb begin
      for (int k = 0; k < NUM_BUTTONS; k++) begin
         cnt_d[k]    = (sync2_q[k] == stable_q[k] || cnt_q[k] == CNT_MAX) ? '0 : cnt_q[k] + 1'b1;
         stable_d[k] = (sync2_q[k] != stable_q[k] && cnt_q[k] == CNT_MAX) ? ~stable_q[k] : stable_q[k];
      end
      // a new event wins over a coincident write-1-to-clear
      press_d   = (press_q & ~((wr_en && addr_lo == 4'd1) ? data[NUM_BUTTONS-1:0] : '0)) | (stable_d & ~stable_q);
      release_d = (release_q & ~((wr_en && addr_lo == 4'd2) ? data[NUM_BUTTONS-1:0] : '0)) | (~stable_d & stable_q);
      irq_en_d  = (wr_en && addr_lo == 4'd3) ? data[NUM_BUTTONS-1:0] : irq_en_q;
      irq_d     = |((press_q | release_q) & irq_en_q);
      for (int i = 0; i < NUM_LEDS; i++) begin
         color_d[i]     = (wr_en && addr_lo == 4'(4 + i)) ? data[14:0] : color_q[i];
         led_d[3*i+2]   = pwm_q < shadow_q[i][14:10];
         led_d[3*i+1]   = pwm_q < shadow_q[i][9:5];
         led_d[3*i]     = pwm_q < shadow_q[i][4:0];
      end
   end

   always_comb begin
      q = '1;
      if (addr_lo == 4'd0) q = DATA_WIDTH'(stable_q);
      if (addr_lo == 4'd1) q = DATA_WIDTH'(press_q);
      if (addr_lo == 4'd2) q = DATA_WIDTH'(release_q);
      if (addr_lo == 4'd3) q = DATA_WIDTH'(irq_en_q);
      for (int i = 0; i < NUM_LEDS; i++)
         if (addr_lo == 4'(4 + i)) q = DATA_WIDTH'(color_q[i]);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         stable_q  <= '0;
         cnt_q     <= '{default: '0};
         press_q   <= '0;
         release_q <= '0;
         irq_en_q  <= '0;
         color_q   <= '{default: '0};
         shadow_q  <= '{default: '0};
         pwm_q     <= '0;
         led_q     <= '0;
         irq_q     <= 1'b0;
      end else begin
         sync1_q   <= buttons;
         sync2_q   <= sync1_q;
         stable_q  <= stable_d;
         cnt_q     <= cnt_d;
         press_q   <= press_d;
         release_q <= release_d;
         irq_en_q  <= irq_en_d;
         color_q   <= color_d;
         pwm_q     <= pwm_q + 1'b1;
         led_q     <= led_d;
         irq_q     <= irq_d;
         if (pwm_q == '1) shadow_q <= color_q;
      end
   end

   assign irq      = irq_q;
   assign led_pins = led_q;
endmodule

// File: tb/tb_button_io_mem.sv
// tb_button_io_mem: directed scenarios for button_io_mem with DEBOUNCE_CYCLES=4.
module tb_button_io_mem;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] data = '0;
   logic [15:0] addr = '0;
   logic        we = 1'b0;
   logic        en = 1'b0;
   logic [15:0] q;
   logic [7:0]  buttons = '0;
   logic        irq;
   logic [5:0]  led_pins;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   button_io_mem #(.DEBOUNCE_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .data(data), .addr(addr), .we(we), .en(en), .q(q),
      .buttons(buttons), .irq(irq), .led_pins(led_pins)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [3:0] a, output logic [15:0] v);
      addr = {12'h000, a};
      #1;
      v = q;
   endtask

   task automatic wr(input logic [3:0] a, input logic [15:0] d);
      addr = {12'h000, a};
      data = d;
      we = 1'b1;
      en = 1'b1;
      tick();
      we = 1'b0;
      en = 1'b0;
   endtask

   task automatic test_reset();
      logic [15:0] v;
      for (int a = 0; a < 6; a++) begin
         rd(4'(a), v);
         checks++;
         if (v !== 16'h0000) begin errors++; $display("FAIL reset_reg%0d: got %h expected 0000", a, v); end
      end
      rd(4'd6, v);
      checks++;
      if (v !== 16'hFFFF) begin errors++; $display("FAIL reset_color2_unmapped: got %h expected FFFF", v); end
      rd(4'd15, v);
      checks++;
      if (v !== 16'hFFFF) begin errors++; $display("FAIL reset_off15: got %h expected FFFF", v); end
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
      checks++;
      if (led_pins !== 6'b0) begin errors++; $display("FAIL reset_leds: got %b expected 000000", led_pins); end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_debounce();
      logic [15:0] v;
      buttons[3] = 1'b1;
      repeat (5) tick();
      rd(4'd0, v);
      checks++;
      if (v !== 16'h0000) begin errors++; $display("FAIL status_early: got %h expected 0000", v); end
      tick();
      rd(4'd0, v);
      checks++;
      if (v !== 16'h0008) begin errors++; $display("FAIL status_at6: got %h expected 0008", v); end
      rd(4'd1, v);
      checks++;
      if (v !== 16'h0008) begin errors++; $display("FAIL press_at6: got %h expected 0008", v); end
      buttons[3] = 1'b0;
      repeat (8) tick();
      rd(4'd2, v);
      checks++;
      if (v !== 16'h0008) begin errors++; $display("FAIL release_set: got %h expected 0008", v); end
      wr(4'd1, 16'h0008);
      wr(4'd2, 16'h0008);
      rd(4'd1, v);
      checks++;
      if (v !== 16'h0000) begin errors++; $display("FAIL press_cleared: got %h expected 0000", v); end
      buttons[3] = 1'b1;
      repeat (3) tick();
      buttons[3] = 1'b0;
      repeat (10) tick();
      rd(4'd0, v);
      checks++;
      if (v !== 16'h0000) begin errors++; $display("FAIL pulse_status: got %h expected 0000", v); end
      rd(4'd1, v);
      checks++;
      if (v !== 16'h0000) begin errors++; $display("FAIL pulse_press: got %h expected 0000", v); end
   endtask

   task automatic test_irq();
      logic [15:0] v;
      wr(4'd3, 16'h0008);
      rd(4'd3, v);
      checks++;
      if (v !== 16'h0008) begin errors++; $display("FAIL irq_en_rb: got %h expected 0008", v); end
      buttons[3] = 1'b1;
      repeat (6) tick();
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL irq_before: got %b expected 0", irq); end
      tick();
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL irq_after_press: got %b expected 1", irq); end
      buttons[3] = 1'b0;
      repeat (8) tick();
      rd(4'd2, v);
      checks++;
      if (v !== 16'h0008) begin errors++; $display("FAIL irq_release: got %h expected 0008", v); end
      wr(4'd1, 16'h0000);
      rd(4'd1, v);
      checks++;
      if (v !== 16'h0008) begin errors++; $display("FAIL w0_unchanged: got %h expected 0008", v); end
      wr(4'd1, 16'h0008);
      wr(4'd2, 16'h0008);
      rd(4'd1, v);
      checks++;
      if (v !== 16'h0000) begin errors++; $display("FAIL clr_press: got %h expected 0000", v); end
      rd(4'd2, v);
      checks++;
      if (v !== 16'h0000) begin errors++; $display("FAIL clr_release: got %h expected 0000", v); end
      tick();
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL irq_dropped: got %b expected 0", irq); end
   endtask

   task automatic test_w1c_collision();
      logic [15:0] v;
      buttons[3] = 1'b1;
      repeat (5) tick();
      wr(4'd1, 16'h0008);
      rd(4'd1, v);
      checks++;
      if (v !== 16'h0008) begin errors++; $display("FAIL collide_press: got %h expected 0008", v); end
      tick();
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL collide_irq: got %b expected 1", irq); end
      wr(4'd3, 16'h0000);
      tick();
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL mask_drop_irq: got %b expected 0", irq); end
      buttons[3] = 1'b0;
      repeat (8) tick();
      wr(4'd1, 16'h0008);
      wr(4'd2, 16'h0008);
   endtask

   task automatic test_pwm();
      logic [15:0] v;
      logic        found;
      int          hi_old [6];
      int          hi_new [6];
      int          exp_old [6];
      int          exp_new [6];
      exp_old = '{31, 0, 16, 0, 0, 0};
      exp_new = '{2, 8, 4, 0, 0, 0};
      hi_old  = '{default: 0};
      hi_new  = '{default: 0};
      wr(4'd4, 16'h401F);
      rd(4'd4, v);
      checks++;
      if (v !== 16'h401F) begin errors++; $display("FAIL color0_rb: got %h expected 401F", v); end
      repeat (40) tick();
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         tick();
         if (led_pins[0] === 1'b0) found = 1'b1;
      end
      checks++;
      if (!found) begin errors++; $display("FAIL pwm_wrap_seen: got 0 expected 1"); end
      for (int j = 1; j <= 64; j++) begin
         if (j == 11) begin
            addr = 16'd4;
            data = 16'h1102;
            we = 1'b1;
            en = 1'b1;
         end
         tick();
         if (j == 11) begin
            we = 1'b0;
            en = 1'b0;
         end
         for (int b = 0; b < 6; b++)
            if (led_pins[b] === 1'b1) begin
               if (j <= 32) hi_old[b]++;
               else hi_new[b]++;
            end
      end
      for (int b = 0; b < 6; b++) begin
         checks++;
         if (hi_old[b] !== exp_old[b]) begin errors++; $display("FAIL pwm_old_bit%0d: got %0d expected %0d", b, hi_old[b], exp_old[b]); end
         checks++;
         if (hi_new[b] !== exp_new[b]) begin errors++; $display("FAIL pwm_new_bit%0d: got %0d expected %0d", b, hi_new[b], exp_new[b]); end
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] v;
      wr(4'd3, 16'h0001);
      buttons[0] = 1'b1;
      repeat (4) tick();
      #3;
      rst = 1'b0;
      #1;
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL rmid_irq: got %b expected 0", irq); end
      checks++;
      if (led_pins !== 6'b0) begin errors++; $display("FAIL rmid_leds: got %b expected 000000", led_pins); end
      rd(4'd3, v);
      checks++;
      if (v !== 16'h0000) begin errors++; $display("FAIL rmid_irq_en: got %h expected 0000", v); end
      rd(4'd4, v);
      checks++;
      if (v !== 16'h0000) begin errors++; $display("FAIL rmid_color0: got %h expected 0000", v); end
      @(negedge clk);
      rst = 1'b1;
      repeat (5) tick();
      rd(4'd1, v);
      checks++;
      if (v !== 16'h0000) begin errors++; $display("FAIL rmid_press_early: got %h expected 0000", v); end
      tick();
      rd(4'd1, v);
      checks++;
      if (v !== 16'h0001) begin errors++; $display("FAIL rmid_press_at6: got %h expected 0001", v); end
   endtask

   initial begin
      #12;
      test_reset();
      test_debounce();
      test_irq();
      test_w1c_collision();
      test_pwm();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
